// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP frame scheduler.
// Holds the FSM state encoding and the width of the drop counter.
package dsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int DROP_W = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry AXI-Stream output register.
// A load takes priority over a drain, so a beat can be replaced in the cycle it transfers.
module axis_reg_slice #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         out_ready,
  output logic [W-1:0] dout,
  output logic         out_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout      <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (ce) begin
      if (load) begin
        dout      <= din;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dsp_frame_scheduler.sv
// Frame scheduler: decimates an always-accepted sample stream into framed
// AXI-Stream output with tuser/tlast markers, frame irq and drop counting.
module dsp_frame_scheduler
  import dsp_pkg::*;
#(
  parameter int DW = 32,
  parameter int LW = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              ce,
  input  logic [LW-1:0]     cfg_len,
  input  logic [7:0]        cfg_decim,
  input  logic              cfg_single,
  input  logic              start,
  input  logic              abort,
  input  logic [DW-1:0]     tdata_s,
  input  logic              tvalid_s,
  output logic              tready_s,
  output logic [DW-1:0]     tdata_m,
  output logic              tvalid_m,
  input  logic              tready_m,
  output logic              tuser_m,
  output logic              tlast_m,
  output logic              busy,
  output logic              irq_frame,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, idx_q;
  logic [7:0]      dec_q, ph_q;
  logic            single_q;
  logic [DROP_W-1:0] drop_q;
  logic            irq_q;

  logic            start_go, acc_run, keep, load, drop, is_last, xfer;
  logic [DW+1:0]   slice_q;

  assign tready_s  = ce;
  assign busy      = (state_q != ST_IDLE);
  assign irq_frame = irq_q;
  assign drop_cnt  = drop_q;
  assign {tlast_m, tuser_m, tdata_m} = slice_q;

  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    xfer     = ce & tvalid_m & tready_m;
    acc_run  = ce & tvalid_s & (state_q == ST_RUN);
    keep     = acc_run & (ph_q == 8'd0);
    // Register is free if empty or draining this same cycle.
    load     = keep & (~tvalid_m | tready_m);
    drop     = keep & ~load;
    is_last  = (idx_q == len_q);
    case (state_q)
      ST_IDLE: if (ce && start) begin
        state_d  = ST_RUN;
        start_go = 1'b1;
      end
      ST_RUN:   if (load && is_last && single_q) state_d = ST_FLUSH;
      ST_FLUSH: if (xfer && tlast_m) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      len_q    <= '0;
      dec_q    <= '0;
      single_q <= 1'b0;
      idx_q    <= '0;
      ph_q     <= '0;
      drop_q   <= '0;
      irq_q    <= 1'b0;
    end else if (abort) begin
      idx_q <= '0;
      ph_q  <= '0;
      irq_q <= 1'b0;
    end else if (ce) begin
      irq_q <= xfer & tlast_m;
      if (start_go) begin
        len_q    <= cfg_len;
        dec_q    <= cfg_decim;
        single_q <= cfg_single;
        idx_q    <= '0;
        ph_q     <= '0;
        drop_q   <= '0;
      end
      if (acc_run) ph_q <= (ph_q == dec_q) ? 8'd0 : ph_q + 8'd1;
      if (drop && drop_q != DROP_MAX) drop_q <= drop_q + DROP_W'(1);
      // Dropped samples leave the index alone so frames never have holes.
      if (load) begin
        if (is_last) begin
          idx_q <= '0;
          if (!single_q) begin
            len_q    <= cfg_len;
            dec_q    <= cfg_decim;
            single_q <= cfg_single;
            ph_q     <= '0;
          end
        end else begin
          idx_q <= idx_q + LW'(1);
        end
      end
    end
  end

  axis_reg_slice #(.W(DW + 2)) u_slice (
    .clk       (hclk),
    .rst       (hreset),
    .ce        (ce),
    .clr       (abort),
    .load      (load),
    .din       ({is_last, (idx_q == '0), tdata_s}),
    .out_ready (tready_m),
    .dout      (slice_q),
    .out_valid (tvalid_m)
  );

endmodule

// File: tb/tb_dsp_frame_scheduler.sv
// Directed bench for dsp_frame_scheduler: ramp input, captured output beats
// compared against hand-computed frames.
module tb_dsp_frame_scheduler;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          hclk = 1'b0;
  logic          hreset, ce, cfg_single, start, abort;
  logic [LW-1:0] cfg_len;
  logic [7:0]    cfg_decim;
  logic [DW-1:0] tdata_s, tdata_m;
  logic          tvalid_s, tready_s, tvalid_m, tready_m, tuser_m, tlast_m;
  logic          busy, irq_frame;
  logic [15:0]   drop_cnt;

  int n_chk = 0;
  int n_err = 0;
  int irq_n = 0;
  logic [DW+1:0] cap[$];

  always #5 hclk = ~hclk;

  dsp_frame_scheduler #(.DW(DW), .LW(LW)) dut (
    .hclk(hclk), .hreset(hreset), .ce(ce), .cfg_len(cfg_len), .cfg_decim(cfg_decim),
    .cfg_single(cfg_single), .start(start), .abort(abort),
    .tdata_s(tdata_s), .tvalid_s(tvalid_s), .tready_s(tready_s),
    .tdata_m(tdata_m), .tvalid_m(tvalid_m), .tready_m(tready_m),
    .tuser_m(tuser_m), .tlast_m(tlast_m), .busy(busy), .irq_frame(irq_frame),
    .drop_cnt(drop_cnt)
  );

  // Output beats and irq pulses, sampled mid-cycle.
  always @(negedge hclk) begin
    if (ce && tvalid_m && tready_m) cap.push_back({tlast_m, tuser_m, tdata_m});
    if (ce && irq_frame) irq_n++;
  end

  // Ramp source: advance after every accepted input beat.
  initial forever begin
    @(posedge hclk);
    if (tvalid_s && ce) begin
      #1;
      tdata_s = tdata_s + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge hclk);
      #1;
    end
  endtask

  task automatic clear_log();
    cap.delete();
    irq_n = 0;
  endtask

  task automatic start_frame(input int len, input int dec, input logic single);
    cfg_len    = LW'(len);
    cfg_decim  = 8'(dec);
    cfg_single = single;
    tvalid_s   = 1'b0;
    start      = 1'b1;
    tick(1);
    start    = 1'b0;
    tdata_s  = '0;
    tvalid_s = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (busy && k < max) begin
      tick(1);
      k++;
    end
    chk(tag, busy, 0);
    tvalid_s = 1'b0;
    tick(2);
  endtask

  task automatic check_frame(input string tag, input int exp_d[$], input int last_i);
    chk({tag, "_n"}, cap.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < cap.size(); i++) begin
      chk({tag, "_d"}, cap[i][DW-1:0], exp_d[i]);
      chk({tag, "_u"}, cap[i][DW], (i == 0));
      chk({tag, "_l"}, cap[i][DW+1], (i == last_i));
    end
  endtask

  initial begin
    hreset = 1'b1; ce = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_len = '0; cfg_decim = '0; cfg_single = 1'b1;
    tdata_s = '0; tvalid_s = 1'b0; tready_m = 1'b1;
    tick(3);
    chk("rst_tvalid", tvalid_m, 0);
    chk("rst_tdata", tdata_m, 0);
    chk("rst_marks", {tuser_m, tlast_m}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq_frame, 0);
    chk("rst_drop", drop_cnt, 0);
    hreset = 1'b0;
    tick(2);

    // 8-beat single frame, no decimation
    clear_log();
    start_frame(7, 0, 1'b1);
    chk("t1_busy", busy, 1);
    wait_idle("t1_idle", 40);
    check_frame("t1", '{0, 1, 2, 3, 4, 5, 6, 7}, 7);
    chk("t1_irq", irq_n, 1);
    chk("t1_tvalid", tvalid_m, 0);

    // decimate by 3
    clear_log();
    start_frame(3, 2, 1'b1);
    wait_idle("t2_idle", 40);
    check_frame("t2", '{0, 3, 6, 9}, 3);
    chk("t2_irq", irq_n, 1);

    // 1-beat frames
    clear_log();
    start_frame(0, 0, 1'b1);
    wait_idle("t3_idle", 20);
    check_frame("t3", '{0}, 0);
    chk("t3_irq", irq_n, 1);

    // continuous 2-beat frames
    clear_log();
    start_frame(1, 0, 1'b0);
    tick(10);
    tvalid_s = 1'b0;
    tick(3);
    chk("t4_busy", busy, 1);
    chk("t4_n", cap.size(), 10);
    for (int i = 0; i < 10 && i < cap.size(); i++) begin
      chk("t4_d", cap[i][DW-1:0], i);
      chk("t4_l", cap[i][DW+1], i % 2);
      chk("t4_u", cap[i][DW], 1 - (i % 2));
    end
    chk("t4_irq", irq_n, 5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t4_abort_busy", busy, 0);

    // backpressure: five kept samples dropped while the register is full
    clear_log();
    start_frame(7, 0, 1'b1);
    tick(3);
    tready_m = 1'b0;
    repeat (5) begin
      tick(1);
      chk("t5_stall_d", tdata_m, 2);
      chk("t5_stall_v", tvalid_m, 1);
    end
    tready_m = 1'b1;
    wait_idle("t5_idle", 40);
    chk("t5_drop", drop_cnt, 5);
    check_frame("t5", '{0, 1, 2, 8, 9, 10, 11, 12}, 7);
    chk("t5_irq", irq_n, 1);

    // abort mid-frame, then a clean frame
    clear_log();
    start_frame(7, 0, 1'b1);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_tvalid", tvalid_m, 0);
    tvalid_s = 1'b0;
    tick(3);
    chk("t6_abort_irq", irq_n, 0);
    clear_log();
    start_frame(7, 0, 1'b1);
    wait_idle("t6_idle", 40);
    check_frame("t6", '{0, 1, 2, 3, 4, 5, 6, 7}, 7);
    chk("t6_irq", irq_n, 1);
    chk("t6_drop_clr", drop_cnt, 0);

    // ce stall, then reset mid-run
    start_frame(7, 0, 1'b1);
    tick(3);
    ce = 1'b0;
    tick(4);
    chk("t7_ready", tready_s, 0);
    chk("t7_hold_d", tdata_m, 2);
    chk("t7_hold_v", tvalid_m, 1);
    chk("t7_hold_busy", busy, 1);
    ce = 1'b1;
    tick(1);
    chk("t7_resume_d", tdata_m, 3);
    chk("t7_resume_u", tuser_m, 0);
    hreset = 1'b1;
    tick(1);
    chk("t7_rst_v", tvalid_m, 0);
    chk("t7_rst_d", tdata_m, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_marks", {tuser_m, tlast_m, irq_frame}, 0);
    hreset = 1'b0;
    tvalid_s = 1'b1;
    tick(3);
    chk("t7_no_autostart", busy, 0);
    chk("t7_no_out", tvalid_m, 0);
    tvalid_s = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
